uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 208 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : Oversampling UART receive stage. Synchronizes the serial
//                line, validates the start bit at mid-bit, samples
//                DATA_BITS data bits LSB-first and checks the stop bit.
//                Good bytes are handed to the host with a ready flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  // Counter widths; both are kept at least one bit wide.
  localparam int c_cnt_w = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int c_pos_w = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_start = 2'd1;
  localparam logic [1:0] c_data  = 2'd2;
  localparam logic [1:0] c_stop  = 2'd3;

  // Start bit is accepted at its middle; every later sample is one full
  // bit period after the previous one.
  localparam logic [c_cnt_w-1:0] c_half_last   = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_sample_last = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_cnt_w-1:0] c_sample_one  = c_cnt_w'(1);
  localparam logic [c_pos_w-1:0] c_bit_last    = c_pos_w'(DATA_BITS - 1);
  localparam logic [c_pos_w-1:0] c_bit_one     = c_pos_w'(1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [c_cnt_w-1:0]   r_sample;
  logic [c_pos_w-1:0]   r_bitpos;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_rdy;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_sample_last;
  logic                 w_stop_tick;
  logic                 w_frame_good;
  logic                 w_frame_bad;

  assign w_sample_last = (r_sample == c_sample_last);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; the FSM only moves on clken ticks.
  always_comb begin
    w_state_nxt = r_state;
    if (clken) begin
      case (r_state)
        c_idle: begin
          if (!r_rx_s) begin
            w_state_nxt = c_start;
          end
        end
        c_start: begin
          // Line back high before mid-bit means a glitch, not a start bit.
          if (r_rx_s) begin
            w_state_nxt = c_idle;
          end else if (r_sample == c_half_last) begin
            w_state_nxt = c_data;
          end
        end
        c_data: begin
          if (w_sample_last && (r_bitpos == c_bit_last)) begin
            w_state_nxt = c_stop;
          end
        end
        c_stop: begin
          if (w_sample_last) begin
            w_state_nxt = c_idle;
          end
        end
        default: begin
          w_state_nxt = c_idle;
        end
      endcase
    end
  end

  // FSM outputs: busy flag and the stop-bit verdict strobes.
  always_comb begin
    rx_busy      = (r_state != c_idle);
    w_stop_tick  = clken && (r_state == c_stop) && w_sample_last;
    w_frame_good = w_stop_tick && r_rx_s;
    w_frame_bad  = w_stop_tick && !r_rx_s;
  end

  // Sample counter, bit index and data shift register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_bitpos <= '0;
      r_shift  <= '0;
    end else if (clken) begin
      case (r_state)
        c_idle: begin
          // The detect tick counts as sample 0 of the start bit.
          if (!r_rx_s) begin
            r_sample <= c_sample_one;
          end else begin
            r_sample <= '0;
          end
        end
        c_start: begin
          if (!r_rx_s) begin
            if (r_sample == c_half_last) begin
              r_sample <= '0;
              r_bitpos <= '0;
            end else begin
              r_sample <= r_sample + c_sample_one;
            end
          end
        end
        c_data: begin
          if (w_sample_last) begin
            r_shift[r_bitpos] <= r_rx_s;
            r_sample          <= '0;
            if (r_bitpos != c_bit_last) begin
              r_bitpos <= r_bitpos + c_bit_one;
            end
          end else begin
            r_sample <= r_sample + c_sample_one;
          end
        end
        c_stop: begin
          if (w_sample_last) begin
            r_sample <= '0;
          end else begin
            r_sample <= r_sample + c_sample_one;
          end
        end
        default: begin
          r_sample <= '0;
        end
      endcase
    end
  end

  // Host-facing flags; a completing byte takes priority over rdy_clr.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_good) begin
        r_data      <= r_shift;
        r_rdy       <= 1'b1;
        r_frame_err <= 1'b0;
        if (r_rdy && !rdy_clr) begin
          r_overrun <= 1'b1;
        end
      end else begin
        if (w_frame_bad) begin
          r_frame_err <= 1'b1;
        end
        if (rdy_clr) begin
          r_rdy     <= 1'b0;
          r_overrun <= 1'b0;
        end
      end
    end
  end

  assign data      = r_data;
  assign rdy       = r_rdy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver. Frames are driven on
//                clken tick boundaries; expected host-side state is queued
//                per frame attempt and compared when rx_busy falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int OS        = 16;
  localparam int CLKDIV    = 27;
  // Busy spans start detect to stop mid-sample: half a bit less one tick,
  // plus eight data bits and the stop bit, each a full bit period.
  localparam int FRAME_LEN = (OS / 2 - 1 + 9 * OS) * CLKDIV;
  localparam int STOP_TICK = 1 + (OS / 2 - 1) + 9 * OS;
  localparam int LIMIT_NS  = 90000 * 20;

  typedef struct {
    logic [7:0] data;
    logic       rdy;
    logic       fe;
    logic       ov;
    int         len;
  } exp_t;

  logic       clk_50m;
  logic       rst_n;
  logic       clken;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  logic done = 1'b0;

  uart_receiver #(
    .DATA_BITS (8),
    .OVERSAMPLE(OS)
  ) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .clken    (clken),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  initial begin
    clk_50m = 1'b0;
    forever #10 clk_50m = ~clk_50m;
  end

  // clken: one cycle in CLKDIV, changing 1 ns after the rising edge.
  initial begin
    clken = 1'b0;
    forever begin
      repeat (CLKDIV - 1) @(posedge clk_50m);
      #1 clken = 1'b1;
      @(posedge clk_50m);
      #1 clken = 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic expect_evt(input logic [7:0] d, input logic r, input logic f,
                            input logic o, input int len);
    exp_t e;
    e.data = d;
    e.rdy  = r;
    e.fe   = f;
    e.ov   = o;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Returns 1 ns after the next clock edge that carried clken.
  task automatic wait_tick();
    do @(posedge clk_50m); while (!clken);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk_50m);
    #1 rdy_clr = 1'b1;
    @(posedge clk_50m);
    #1 rdy_clr = 1'b0;
  endtask

  // Drives one frame aligned to ticks. clr_at_done raises rdy_clr only in
  // the cycle of the stop mid-sample; abort_at >= 0 asserts reset before
  // that tick index and returns.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit clr_at_done, input int abort_at);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    wait_tick();
    for (int k = 0; k < 10 * OS; k++) begin
      if (k == abort_at) begin
        #5 rst_n = 1'b0;
        return;
      end
      if (k == STOP_TICK) rx = 1'b1;
      else if ((k % OS) == 0) rx = bits[k / OS];
      if (clr_at_done && (k == STOP_TICK - 1)) begin
        do begin @(posedge clk_50m); #2; end while (!clken);
        rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1 rdy_clr = 1'b0;
      end else begin
        wait_tick();
      end
    end
    rx = 1'b1;
  endtask

  // Scoreboard: every end of a frame attempt pops one expected state.
  always @(negedge clk_50m) begin
    if (rx_busy) begin
      busy_len++;
    end else if (prev_busy) begin
      check_val("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_val("data", data, e.data);
        check_val("rdy", rdy, e.rdy);
        check_val("frame_err", frame_err, e.fe);
        check_val("overrun", overrun, e.ov);
        if (e.len != 0) check_val("busy_len", busy_len, e.len);
      end
      busy_len = 0;
    end
    prev_busy = rx_busy;
  end

  initial begin
    #(LIMIT_NS);
    check_val("timeout_done", done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    repeat (5) @(posedge clk_50m);
    #1;
    check_val("rst_data", data, 8'h00);
    check_val("rst_rdy", rdy, 0);
    check_val("rst_fe", frame_err, 0);
    check_val("rst_ov", overrun, 0);
    check_val("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    repeat (3) wait_tick();

    // Basic frame
    expect_evt(8'hA5, 1, 0, 0, FRAME_LEN);
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    repeat (4) wait_tick();
    pulse_clr();
    @(negedge clk_50m);
    check_val("clr_rdy_a5", rdy, 0);

    // Four-tick glitch: false start, nothing changes
    expect_evt(8'hA5, 0, 0, 0, 4 * CLKDIV);
    wait_tick();
    rx = 1'b0;
    repeat (4) wait_tick();
    rx = 1'b1;
    repeat (20) wait_tick();
    expect_evt(8'h3C, 1, 0, 0, FRAME_LEN);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    pulse_clr();

    // Framing error then recovery
    expect_evt(8'h3C, 0, 1, 0, FRAME_LEN);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    expect_evt(8'h7E, 1, 0, 0, FRAME_LEN);
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    pulse_clr();

    // Overrun
    expect_evt(8'h11, 1, 0, 0, FRAME_LEN);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    expect_evt(8'h22, 1, 0, 1, FRAME_LEN);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    pulse_clr();
    @(negedge clk_50m);
    check_val("clr_rdy_ov", rdy, 0);
    check_val("clr_ov", overrun, 0);

    // rdy_clr coincident with completion: set wins, no overrun
    expect_evt(8'h33, 1, 0, 0, FRAME_LEN);
    send_frame(8'h33, 1'b1, 1'b0, -1);
    expect_evt(8'h55, 1, 0, 0, FRAME_LEN);
    send_frame(8'h55, 1'b1, 1'b1, -1);

    // Reset during data bit 3
    expect_evt(8'h00, 0, 0, 0, 0);
    send_frame(8'hF0, 1'b1, 1'b0, 3 * OS + OS + 8);
    #1;
    check_val("abort_data", data, 8'h00);
    check_val("abort_rdy", rdy, 0);
    check_val("abort_busy", rx_busy, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1 rst_n = 1'b1;
    repeat (5) wait_tick();
    check_val("post_abort_rdy", rdy, 0);
    check_val("post_abort_busy", rx_busy, 0);
    expect_evt(8'h0F, 1, 0, 0, FRAME_LEN);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    repeat (4) wait_tick();

    check_val("sb_drained", sb.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
